// File: rtl/estagio_idex.sv
// ID/EX pipeline register with ALU control decode and operand forwarding.
// Optional forwarding from MEM/WB is enabled by defining ENCAMINHAMENTO_EN.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall, flush          hold the stage / load a bubble (flush wins)
//   id_*                  decoded instruction fields from ID
//   mem_*, wb_*           forwarding sources (used only with ENCAMINHAMENTO_EN)
//   SrcA, SrcB            ALU operands
//   ULAcontrole           3-bit ALU operation
//   ex_valido             stored instruction is valid
//   ex_RegWrite           write enable qualified by valido
//   ex_rdestino           destination register number
//   ex_dadoEscrita        forwarded rt value for stores
//   ex_funct_invalido     valid R-type with an unsupported funct
module estagio_idex (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        id_valido,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [31:0] id_dadoA,
   input  logic [31:0] id_dadoB,
   input  logic [31:0] id_imediato,
   input  logic [1:0]  id_ALUOp,
   input  logic [5:0]  id_funct,
   input  logic        id_ALUSrc,
   input  logic        id_RegDst,
   input  logic        id_RegWrite,
   input  logic        mem_RegWrite,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_ULAsaida,
   input  logic        wb_RegWrite,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_dado,
   output logic [31:0] SrcA,
   output logic [31:0] SrcB,
   output logic [2:0]  ULAcontrole,
   output logic        ex_valido,
   output logic        ex_RegWrite,
   output logic [4:0]  ex_rdestino,
   output logic [31:0] ex_dadoEscrita,
   output logic        ex_funct_invalido
);

   logic        valido_q;
   logic [4:0]  rs_q;
   logic [4:0]  rt_q;
   logic [4:0]  rd_q;
   logic [31:0] dadoa_q;
   logic [31:0] dadob_q;
   logic [31:0] imediato_q;
   logic [1:0]  aluop_q;
   logic [5:0]  funct_q;
   logic        alusrc_q;
   logic        regdst_q;
   logic        regwrite_q;

   logic [31:0] fwd_a;
   logic [31:0] fwd_b;

   // Reset and flush both produce an all-zero bubble.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         valido_q   <= 1'b0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         dadoa_q    <= '0;
         dadob_q    <= '0;
         imediato_q <= '0;
         aluop_q    <= '0;
         funct_q    <= '0;
         alusrc_q   <= 1'b0;
         regdst_q   <= 1'b0;
         regwrite_q <= 1'b0;
      end else if (!stall) begin
         valido_q   <= id_valido;
         rs_q       <= id_rs;
         rt_q       <= id_rt;
         rd_q       <= id_rd;
         dadoa_q    <= id_dadoA;
         dadob_q    <= id_dadoB;
         imediato_q <= id_imediato;
         aluop_q    <= id_ALUOp;
         funct_q    <= id_funct;
         alusrc_q   <= id_ALUSrc;
         regdst_q   <= id_RegDst;
         regwrite_q <= id_RegWrite;
      end
   end

   always_comb begin
      ULAcontrole       = 3'b010;
      ex_funct_invalido = 1'b0;
      unique case (aluop_q)
         2'b00: ULAcontrole = 3'b010;
         2'b01: ULAcontrole = 3'b110;
         2'b11: ULAcontrole = 3'b001;
         default: begin
            unique case (funct_q)
               6'b100000: ULAcontrole = 3'b010;
               6'b100010: ULAcontrole = 3'b110;
               6'b100100: ULAcontrole = 3'b000;
               6'b100101: ULAcontrole = 3'b001;
               6'b101010: ULAcontrole = 3'b111;
               default: begin
                  ULAcontrole       = 3'b010;
                  ex_funct_invalido = valido_q;
               end
            endcase
         end
      endcase
   end

`ifdef ENCAMINHAMENTO_EN
   logic mem_hit_a;
   logic mem_hit_b;
   logic wb_hit_a;
   logic wb_hit_b;

   // Register 0 is hardwired, so a write to it never forwards.
   assign mem_hit_a = mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == rs_q);
   assign mem_hit_b = mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == rt_q);
   assign wb_hit_a  = wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == rs_q);
   assign wb_hit_b  = wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == rt_q);

   // MEM holds the younger result, so it wins over WB.
   always_comb begin
      fwd_a = dadoa_q;
      if (mem_hit_a)
         fwd_a = mem_ULAsaida;
      else if (wb_hit_a)
         fwd_a = wb_dado;
   end

   always_comb begin
      fwd_b = dadob_q;
      if (mem_hit_b)
         fwd_b = mem_ULAsaida;
      else if (wb_hit_b)
         fwd_b = wb_dado;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{mem_RegWrite, mem_rd, mem_ULAsaida,
                         wb_RegWrite, wb_rd, wb_dado};
   assign fwd_a = dadoa_q;
   assign fwd_b = dadob_q;
`endif

   assign SrcA           = fwd_a;
   assign SrcB           = alusrc_q ? imediato_q : fwd_b;
   assign ex_dadoEscrita = fwd_b;
   assign ex_valido      = valido_q;
   assign ex_RegWrite    = regwrite_q && valido_q;
   assign ex_rdestino    = regdst_q ? rd_q : rt_q;

endmodule

// File: tb/tb_estagio_idex.sv
// Self-checking bench for estagio_idex: directed cases plus random stimulus
// compared every cycle against a behavioural model of the stage.
module tb_estagio_idex;

   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic        id_valido;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_dadoA, id_dadoB, id_imediato;
   logic [1:0]  id_ALUOp;
   logic [5:0]  id_funct;
   logic        id_ALUSrc, id_RegDst, id_RegWrite;
   logic        mem_RegWrite, wb_RegWrite;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_ULAsaida, wb_dado;
   logic [31:0] SrcA, SrcB, ex_dadoEscrita;
   logic [2:0]  ULAcontrole;
   logic        ex_valido, ex_RegWrite, ex_funct_invalido;
   logic [4:0]  ex_rdestino;

   int total = 0;
   int bad = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   estagio_idex dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valido(id_valido), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_dadoA(id_dadoA), .id_dadoB(id_dadoB), .id_imediato(id_imediato),
      .id_ALUOp(id_ALUOp), .id_funct(id_funct), .id_ALUSrc(id_ALUSrc),
      .id_RegDst(id_RegDst), .id_RegWrite(id_RegWrite),
      .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd),
      .mem_ULAsaida(mem_ULAsaida), .wb_RegWrite(wb_RegWrite),
      .wb_rd(wb_rd), .wb_dado(wb_dado),
      .SrcA(SrcA), .SrcB(SrcB), .ULAcontrole(ULAcontrole),
      .ex_valido(ex_valido), .ex_RegWrite(ex_RegWrite),
      .ex_rdestino(ex_rdestino), .ex_dadoEscrita(ex_dadoEscrita),
      .ex_funct_invalido(ex_funct_invalido)
   );

   typedef struct {
      bit        v;
      bit [4:0]  rs, rt, rd;
      bit [31:0] a, b, imm;
      bit [1:0]  op;
      bit [5:0]  fn;
      bit        src, dst, wr;
   } instr_t;

   instr_t m = '{default: 0};

   // The stage holds whatever instruction was last accepted.
   always @(posedge clk) begin
      if (reset || flush)
         m = '{default: 0};
      else if (!stall)
         m = '{id_valido, id_rs, id_rt, id_rd, id_dadoA, id_dadoB,
               id_imediato, id_ALUOp, id_funct, id_ALUSrc, id_RegDst,
               id_RegWrite};
   end

   function automatic logic [31:0] fwd(input logic [4:0] r,
                                       input logic [31:0] d);
`ifdef ENCAMINHAMENTO_EN
      if (mem_RegWrite && mem_rd != 0 && mem_rd == r) return mem_ULAsaida;
      if (wb_RegWrite && wb_rd != 0 && wb_rd == r) return wb_dado;
`endif
      return d;
   endfunction

   function automatic bit known_fn(input logic [5:0] f);
      return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
   endfunction

   function automatic logic [2:0] ula(input logic [1:0] op,
                                      input logic [5:0] f);
      if (op == 0) return 3'd2;
      if (op == 1) return 3'd6;
      if (op == 3) return 3'd1;
      if (f == 6'h22) return 3'd6;
      if (f == 6'h24) return 3'd0;
      if (f == 6'h25) return 3'd1;
      if (f == 6'h2a) return 3'd7;
      return 3'd2;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m_srca", SrcA, fwd(m.rs, m.a));
         cmp("m_srcb", SrcB, m.src ? m.imm : fwd(m.rt, m.b));
         cmp("m_dado", ex_dadoEscrita, fwd(m.rt, m.b));
         cmp("m_ula", 32'(ULAcontrole), 32'(ula(m.op, m.fn)));
         cmp("m_val", 32'(ex_valido), 32'(m.v));
         cmp("m_wr", 32'(ex_RegWrite), 32'(m.wr & m.v));
         cmp("m_dst", 32'(ex_rdestino), 32'(m.dst ? m.rd : m.rt));
         cmp("m_inv", 32'(ex_funct_invalido),
             32'(m.v && m.op == 2 && !known_fn(m.fn)));
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic clear_all;
      reset = 0; stall = 0; flush = 0;
      id_valido = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_dadoA = 0; id_dadoB = 0; id_imediato = 0;
      id_ALUOp = 0; id_funct = 0;
      id_ALUSrc = 0; id_RegDst = 0; id_RegWrite = 0;
      mem_RegWrite = 0; mem_rd = 0; mem_ULAsaida = 0;
      wb_RegWrite = 0; wb_rd = 0; wb_dado = 0;
   endtask

   task automatic rand_id;
      id_valido = 1'($urandom); id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom);
      id_dadoA = $urandom; id_dadoB = $urandom; id_imediato = $urandom;
      id_ALUOp = 2'($urandom);
      case ($urandom_range(0, 5))
         0: id_funct = 6'h20;
         1: id_funct = 6'h22;
         2: id_funct = 6'h24;
         3: id_funct = 6'h25;
         4: id_funct = 6'h2a;
         default: id_funct = 6'($urandom);
      endcase
      id_ALUSrc = 1'($urandom); id_RegDst = 1'($urandom);
      id_RegWrite = 1'($urandom);
   endtask

   task automatic load_x;
      id_valido = 1; id_RegWrite = 1; id_RegDst = 0;
      id_rs = 7; id_rt = 9; id_rd = 5; id_ALUOp = 1; id_funct = 0;
      id_dadoA = 32'h11; id_dadoB = 32'h22; id_ALUSrc = 0;
   endtask

   initial begin
      clear_all();
      reset = 1;
      tick();
      chk_en = 1;
      reset = 0;
      @(negedge clk);
      cmp("rst_val", 32'(ex_valido), 0);
      cmp("rst_wr", 32'(ex_RegWrite), 0);
      cmp("rst_dst", 32'(ex_rdestino), 0);
      cmp("rst_ula", 32'(ULAcontrole), 2);
      cmp("rst_srca", SrcA, 0);
      #1;

      id_ALUOp = 2; id_funct = 6'h20; id_dadoA = 5; id_dadoB = 7;
      id_valido = 1; id_RegWrite = 1; id_RegDst = 1; id_rd = 3;
      id_rs = 1; id_rt = 2;
      tick();
      @(negedge clk);
      cmp("add_ula", 32'(ULAcontrole), 2);
      cmp("add_srca", SrcA, 5);
      cmp("add_srcb", SrcB, 7);
      cmp("add_dst", 32'(ex_rdestino), 3);
      cmp("add_wr", 32'(ex_RegWrite), 1);
      #1;

      id_rs = 4; id_dadoA = 1;
      tick();
      mem_RegWrite = 1; mem_rd = 4; mem_ULAsaida = 32'hAA;
      wb_RegWrite = 1; wb_rd = 4; wb_dado = 32'hBB;
      @(negedge clk);
`ifdef ENCAMINHAMENTO_EN
      cmp("fwd_mem", SrcA, 32'hAA);
`else
      cmp("fwd_off", SrcA, 1);
`endif
      #1;
      mem_RegWrite = 0;
      @(negedge clk);
`ifdef ENCAMINHAMENTO_EN
      cmp("fwd_wb", SrcA, 32'hBB);
`else
      cmp("fwd_off2", SrcA, 1);
`endif
      #1;
      wb_RegWrite = 0;

      id_rt = 0; id_dadoB = 0; id_ALUSrc = 0;
      tick();
      mem_RegWrite = 1; mem_rd = 0; mem_ULAsaida = 32'hFFFF;
      wb_RegWrite = 1; wb_rd = 0; wb_dado = 32'h1234;
      @(negedge clk);
      cmp("r0_srcb", SrcB, 0);
      cmp("r0_dado", ex_dadoEscrita, 0);
      #1;
      mem_RegWrite = 0; wb_RegWrite = 0;

      load_x();
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         rand_id();
         tick();
         @(negedge clk);
         cmp("stl_ula", 32'(ULAcontrole), 6);
         cmp("stl_srca", SrcA, 32'h11);
         cmp("stl_srcb", SrcB, 32'h22);
         cmp("stl_dst", 32'(ex_rdestino), 9);
         cmp("stl_wr", 32'(ex_RegWrite), 1);
         #1;
      end
      load_x();
      flush = 1;
      tick();
      @(negedge clk);
      cmp("sf_val", 32'(ex_valido), 0);
      cmp("sf_wr", 32'(ex_RegWrite), 0);
      #1;
      flush = 0; stall = 0;

      load_x();
      tick();
      stall = 1; reset = 1;
      tick();
      @(negedge clk);
      cmp("rs_val", 32'(ex_valido), 0);
      cmp("rs_dst", 32'(ex_rdestino), 0);
      cmp("rs_srca", SrcA, 0);
      #1;
      stall = 0; reset = 0;

      id_valido = 1; id_ALUOp = 2; id_funct = 6'h2a;
      tick();
      @(negedge clk);
      cmp("slt_ula", 32'(ULAcontrole), 7);
      #1;
      id_funct = 6'h07;
      tick();
      @(negedge clk);
      cmp("bad_ula", 32'(ULAcontrole), 2);
      cmp("bad_inv", 32'(ex_funct_invalido), 1);
      #1;
      id_ALUOp = 0; id_ALUSrc = 1; id_imediato = 32'hFFFFFFFC;
      tick();
      @(negedge clk);
      cmp("imm_srcb", SrcB, 32'hFFFFFFFC);
      cmp("imm_ula", 32'(ULAcontrole), 2);
      cmp("imm_inv", 32'(ex_funct_invalido), 0);
      #1;

      for (int n = 0; n < 2000; n++) begin
         rand_id();
         reset = ($urandom_range(0, 99) < 3);
         flush = ($urandom_range(0, 99) < 10);
         stall = ($urandom_range(0, 99) < 25);
         mem_RegWrite = 1'($urandom); mem_rd = 5'($urandom_range(0, 3));
         mem_ULAsaida = $urandom;
         wb_RegWrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 3));
         wb_dado = $urandom;
         tick();
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
